// File: rtl/shift_seq.sv
// rtl/shift_seq.sv - sequencer for a 4-bit universal shift register: load, N shifts, done
//
// Ports:
//   CLK, CLR_N      clock (rising edge) and asynchronous active-low clear
//   REQ             start request, sampled only while idle
//   DIR             shift direction: 0 = right (fill via SIR), 1 = left (fill via SIL)
//   CNT[3:0]        number of shift cycles after the load cycle
//   FILL[1:0]       serial fill: 00 zero, 01 one, 10 rotate, 11 zero
//   ABORT           cancel an operation that is in LOAD or SHIFT
//   Q0, Q3          end taps of the controlled shift register
//   S1, S0          register mode: 00 hold, 01 right, 10 left, 11 load
//   SIR, SIL        serial right / left inputs to the register
//   ACK             one-cycle pulse in the LOAD cycle of an accepted request
//   BUSY            high while not idle
//   DONE            one-cycle completion pulse
//   REM[3:0]        shift cycles still to be issued

module shift_seq (
  input  logic       CLK,
  input  logic       CLR_N,
  input  logic       REQ,
  input  logic       DIR,
  input  logic [3:0] CNT,
  input  logic [1:0] FILL,
  input  logic       ABORT,
  input  logic       Q0,
  input  logic       Q3,
  output logic       S1,
  output logic       S0,
  output logic       SIR,
  output logic       SIL,
  output logic       ACK,
  output logic       BUSY,
  output logic       DONE,
  output logic [3:0] REM
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic       dir_q, dir_d;
  logic [1:0] fill_q, fill_d;
  logic [3:0] rem_q, rem_d;
  logic       s1_q, s1_d;
  logic       s0_q, s0_d;
  logic       ack_q, ack_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  // Next state and captured operands.
  // REM counts the shift cycles still to issue, including the current one,
  // so the first SHIFT cycle still shows the full count and the last shows 1.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    fill_d  = fill_q;
    rem_d   = rem_q;
    unique case (state_q)
      ST_IDLE: begin
        // REQ beats ABORT here: ABORT has no meaning while idle.
        if (REQ) begin
          state_d = ST_LOAD;
          dir_d   = DIR;
          fill_d  = FILL;
          rem_d   = CNT;
        end
      end
      ST_LOAD: begin
        if (ABORT) begin
          state_d = ST_IDLE;
          rem_d   = 4'd0;
        end else if (rem_q != 4'd0) begin
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_FIN;
        end
      end
      ST_SHIFT: begin
        if (ABORT) begin
          state_d = ST_IDLE;
          rem_d   = 4'd0;
        end else if (rem_q > 4'd1) begin
          rem_d = rem_q - 4'd1;
        end else begin
          // Last shift issued; saturate at zero rather than wrap.
          state_d = ST_FIN;
          rem_d   = 4'd0;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        rem_d   = 4'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they land in flops aligned
  // with the state they describe.
  always_comb begin
    s1_d   = 1'b0;
    s0_d   = 1'b0;
    ack_d  = 1'b0;
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_FIN);
    unique case (state_d)
      ST_LOAD: begin
        s1_d  = 1'b1;
        s0_d  = 1'b1;
        ack_d = 1'b1;
      end
      ST_SHIFT: begin
        s1_d = dir_d;
        s0_d = ~dir_d;
      end
      default: begin
        s1_d = 1'b0;
        s0_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q <= ST_IDLE;
      dir_q   <= 1'b0;
      fill_q  <= 2'b00;
      rem_q   <= 4'd0;
      s1_q    <= 1'b0;
      s0_q    <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      fill_q  <= fill_d;
      rem_q   <= rem_d;
      s1_q    <= s1_d;
      s0_q    <= s0_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Serial fill is combinational so a rotate sees the live end tap.
  always_comb begin
    SIR = 1'b0;
    SIL = 1'b0;
    if (state_q == ST_LOAD || state_q == ST_SHIFT) begin
      unique case (fill_q)
        2'b01: begin
          SIR = 1'b1;
          SIL = 1'b1;
        end
        2'b10: begin
          SIR = Q3;
          SIL = Q0;
        end
        default: begin
          SIR = 1'b0;
          SIL = 1'b0;
        end
      endcase
    end
  end

  assign S1   = s1_q;
  assign S0   = s0_q;
  assign ACK  = ack_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign REM  = rem_q;

endmodule

// File: tb/tb_shift_seq.sv
// tb/tb_shift_seq.sv - directed self-checking bench for shift_seq

module tb_shift_seq;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic       req = 1'b0;
  logic       dir = 1'b0;
  logic [3:0] cnt = 4'd0;
  logic [1:0] fill = 2'b00;
  logic       abort = 1'b0;
  logic       s1, s0, sir, sil, ack, busy, done;
  logic [3:0] rem;

  logic [3:0] mq = 4'b0000;
  logic [3:0] pdata = 4'b0000;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  shift_seq dut (
    .CLK   (clk),
    .CLR_N (clr_n),
    .REQ   (req),
    .DIR   (dir),
    .CNT   (cnt),
    .FILL  (fill),
    .ABORT (abort),
    .Q0    (mq[0]),
    .Q3    (mq[3]),
    .S1    (s1),
    .S0    (s0),
    .SIR   (sir),
    .SIL   (sil),
    .ACK   (ack),
    .BUSY  (busy),
    .DONE  (done),
    .REM   (rem)
  );

  // Universal shift register under control of the sequencer.
  always @(posedge clk) begin
    case ({s1, s0})
      2'b11:   mq <= pdata;
      2'b01:   mq <= {mq[2:0], sir};
      2'b10:   mq <= {sil, mq[3:1]};
      default: mq <= mq;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] outs();
    return {19'd0, s1, s0, sir, sil, ack, busy, done, rem, 2'b00};
  endfunction

  logic [1:0] t1_s[5]    = '{2'b11, 2'b01, 2'b01, 2'b01, 2'b00};
  logic [3:0] t1_rem[5]  = '{4'd3, 4'd3, 4'd2, 4'd1, 4'd0};
  logic       t1_done[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [3:0] rot_q[4]   = '{4'b1011, 4'b1101, 4'b1110, 4'b0111};

  initial begin
    // Reset state
    #3;
    check_eq("reset_outs", outs(), 32'd0);
    tick();
    check_eq("reset_outs_edge", outs(), 32'd0);
    #2 clr_n = 1'b1;
    tick();

    // Right shift, CNT=3, zero fill
    req = 1'b1; dir = 1'b0; cnt = 4'd3; fill = 2'b00;
    tick();
    req = 1'b0;
    check_eq("t1_ack", ack, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("t1_s%0d", i), {s1, s0}, t1_s[i]);
      check_eq($sformatf("t1_rem%0d", i), rem, t1_rem[i]);
      check_eq($sformatf("t1_done%0d", i), done, t1_done[i]);
      check_eq($sformatf("t1_busy%0d", i), busy, 1'b1);
      check_eq($sformatf("t1_sir%0d", i), sir, 1'b0);
      tick();
    end
    check_eq("t1_idle_busy", busy, 1'b0);
    check_eq("t1_idle_done", done, 1'b0);

    // CNT=0, DIR=1: load then finish, never a left shift
    req = 1'b1; dir = 1'b1; cnt = 4'd0; fill = 2'b00;
    tick();
    req = 1'b0;
    check_eq("t2_load", {s1, s0}, 2'b11);
    check_eq("t2_rem", rem, 4'd0);
    tick();
    check_eq("t2_fin_s", {s1, s0}, 2'b00);
    check_eq("t2_done", done, 1'b1);
    tick();
    check_eq("t2_idle", {busy, done, s1, s0}, 4'b0000);

    // Left rotate of 1011 by 4 returns to 1011
    pdata = 4'b1011;
    req = 1'b1; dir = 1'b1; cnt = 4'd4; fill = 2'b10;
    tick();
    req = 1'b0;
    check_eq("t3_load", {s1, s0}, 2'b11);
    tick();
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("t3_s%0d", i), {s1, s0}, 2'b10);
      check_eq($sformatf("t3_q%0d", i), mq, rot_q[i]);
      check_eq($sformatf("t3_sil%0d", i), sil, rot_q[i][0]);
      check_eq($sformatf("t3_sir%0d", i), sir, rot_q[i][3]);
      tick();
    end
    check_eq("t3_done", done, 1'b1);
    check_eq("t3_final_q", mq, 4'b1011);
    check_eq("t3_fin_sil", sil, 1'b0);
    tick();

    // CNT=15, abort in third shift cycle
    req = 1'b1; dir = 1'b0; cnt = 4'd15; fill = 2'b00;
    tick();
    req = 1'b0;
    tick();
    check_eq("t4_rem1", rem, 4'd15);
    tick();
    tick();
    check_eq("t4_rem3", rem, 4'd13);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("t4_abort_s", {s1, s0}, 2'b00);
    check_eq("t4_abort_rem", rem, 4'd0);
    check_eq("t4_abort_busy", busy, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("t4_nodone%0d", i), done, 1'b0);
      tick();
    end

    // REQ with ABORT in idle is accepted; ABORT in FIN changes nothing
    req = 1'b1; abort = 1'b1; cnt = 4'd0;
    tick();
    req = 1'b0; abort = 1'b0;
    check_eq("t7_ack", ack, 1'b1);
    tick();
    abort = 1'b1;
    check_eq("t7_fin_done", done, 1'b1);
    tick();
    abort = 1'b0;
    check_eq("t7_idle", busy, 1'b0);

    // Clear in the middle of SHIFT, REQ held high
    req = 1'b1; dir = 1'b0; cnt = 4'd5; fill = 2'b01;
    tick();
    tick();
    tick();
    check_eq("t5_sir_shift", sir, 1'b1);
    #1 clr_n = 1'b0;
    #1;
    check_eq("t5_clr_outs", outs(), 32'd0);
    tick();
    check_eq("t5_clr_hold", outs(), 32'd0);
    #2 clr_n = 1'b1;
    tick();
    req = 1'b0;
    check_eq("t5_relaunch_ack", ack, 1'b1);
    check_eq("t5_relaunch_s", {s1, s0}, 2'b11);
    check_eq("t5_relaunch_rem", rem, 4'd5);
    begin
      int guard = 0;
      while (!done && guard < 30) begin
        tick();
        guard++;
      end
      check_eq("t5_done_seen", done, 1'b1);
      check_eq("t5_latency", guard, 6);
    end
    tick();

    // Back-to-back with REQ held high, CNT=1: LOAD SHIFT FIN IDLE repeating
    req = 1'b1; dir = 1'b0; cnt = 4'd1; fill = 2'b00;
    for (int i = 0; i < 12; i++) begin
      tick();
      check_eq($sformatf("t6_ack%0d", i), ack, (i % 4) == 0);
      check_eq($sformatf("t6_busy%0d", i), busy, (i % 4) != 3);
      check_eq($sformatf("t6_done%0d", i), done, (i % 4) == 2);
    end
    req = 1'b0;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
